// File: rtl/nml_mux_arbiter_if.sv
// nml_mux_arbiter_if
// Handshake and data bundle between two requesters, the NML majority-mux
// arbiter and the downstream consumer.
//   in1_valid/in1_data/in1_ready : requester 1 stream
//   in2_valid/in2_data/in2_ready : requester 2 stream
//   select                       : registered mux select (0 = in1, 1 = in2)
//   out_valid/out_data/out_src/out_ready : pipelined output stream + source tag
//   in1_lock/in2_lock            : burst locks, present only with NML_ARB_LOCK_EN
// Modports: master = requesters/consumer side, slave = arbiter side.
interface nml_mux_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             in2_valid;
  logic [WIDTH-1:0] in2_data;
  logic             in2_ready;
  logic             select;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
`ifdef NML_ARB_LOCK_EN
  logic             in1_lock;
  logic             in2_lock;

  modport master (
    output in1_valid, in1_data, in2_valid, in2_data, out_ready, in1_lock, in2_lock,
    input  in1_ready, in2_ready, select, out_valid, out_data, out_src
  );
  modport slave (
    input  in1_valid, in1_data, in2_valid, in2_data, out_ready, in1_lock, in2_lock,
    output in1_ready, in2_ready, select, out_valid, out_data, out_src
  );
`else
  modport master (
    output in1_valid, in1_data, in2_valid, in2_data, out_ready,
    input  in1_ready, in2_ready, select, out_valid, out_data, out_src
  );
  modport slave (
    input  in1_valid, in1_data, in2_valid, in2_data, out_ready,
    output in1_ready, in2_ready, select, out_valid, out_data, out_src
  );
`endif
endinterface

// File: rtl/nml_mux_arbiter.sv
// nml_mux_arbiter
// Two-requester round-robin arbiter driving a bitwise 2:1 multiplexer built
// from 3-input majority gates, out = M(M(sel,in2,0), M(~sel,in1,0), 1).
// The granted word is carried through a STAGES-deep pipeline (NML clock
// zones) together with a source tag. The whole pipeline stalls together
// when the output is valid and not accepted.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : nml_mux_arbiter_if.slave (request/grant handshakes, output stream)
// Optional feature macro: NML_ARB_LOCK_EN (burst lock inputs in1_lock/in2_lock
// keep the current grant across transfers while the granted side holds lock).
module nml_mux_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 3
) (
  input  logic                clk,
  input  logic                reset,
  nml_mux_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, GNT1, GNT2} state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  // 0 = in1 served last, 1 = in2 served last
  logic             last_q, last_d;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] src_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  logic             adv;
  logic             xfer1, xfer2, xfer;
  logic             lock1, lock2;
  logic [WIDTH-1:0] mux_w;
  logic [WIDTH-1:0] stg0_data_d;
  logic             stg0_src_d;

  function automatic logic [WIDTH-1:0] maj(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [WIDTH-1:0] c);
    return (c & (a ^ b)) | (a & b);
  endfunction

`ifdef NML_ARB_LOCK_EN
  assign lock1 = bus.in1_lock;
  assign lock2 = bus.in2_lock;
`else
  assign lock1 = 1'b0;
  assign lock2 = 1'b0;
`endif

  // Majority with a 0 input is AND, with a 1 input is OR.
  assign mux_w = maj(maj({WIDTH{sel_q}},  bus.in2_data, '0),
                     maj({WIDTH{~sel_q}}, bus.in1_data, '0),
                     '1);

  assign adv           = ~vld_q[STAGES-1] | bus.out_ready;
  assign bus.in1_ready = (state_q == GNT1) & adv;
  assign bus.in2_ready = (state_q == GNT2) & adv;
  assign xfer1         = bus.in1_valid & bus.in1_ready;
  assign xfer2         = bus.in2_valid & bus.in2_ready;
  assign xfer          = xfer1 | xfer2;

  // Bubbles carry zero data/src so idle stages never show stale words.
  assign stg0_data_d = mux_w & {WIDTH{xfer}};
  assign stg0_src_d  = sel_q & xfer;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (xfer1) last_d = 1'b0;
    if (xfer2) last_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.in1_valid & bus.in2_valid) state_d = last_q ? GNT1 : GNT2;
        else if (bus.in1_valid)            state_d = GNT1;
        else if (bus.in2_valid)            state_d = GNT2;
      end
      // A transfer implies the granted valid is high this cycle, so after a
      // transfer the choice is only between handing over and keeping it.
      GNT1: begin
        if (xfer1)               state_d = (bus.in2_valid & ~lock1) ? GNT2 : GNT1;
        else if (~bus.in1_valid) state_d = IDLE;
      end
      GNT2: begin
        if (xfer2)               state_d = (bus.in1_valid & ~lock2) ? GNT1 : GNT2;
        else if (~bus.in2_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GNT1)      sel_d = 1'b0;
    else if (state_d == GNT2) sel_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      vld_q   <= '0;
      src_q   <= '0;
      for (int unsigned i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      if (adv) begin
        vld_q[0]  <= xfer;
        src_q[0]  <= stg0_src_d;
        data_q[0] <= stg0_data_d;
        for (int unsigned i = 1; i < STAGES; i++) begin
          vld_q[i]  <= vld_q[i-1];
          src_q[i]  <= src_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign bus.select    = sel_q;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];
  assign bus.out_src   = src_q[STAGES-1];

endmodule

// File: tb/tb_nml_mux_arbiter.sv
module tb_nml_mux_arbiter;

  localparam int S = 3;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  nml_mux_arbiter_if #(.WIDTH(8)) bus ();

  nml_mux_arbiter #(.WIDTH(8), .STAGES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       v1;
    bit [7:0] d1;
    bit       v2;
    bit [7:0] d2;
    bit       ordy;
    bit       r1;
    bit       r2;
    bit       ov;
    bit [7:0] od;
    bit       os;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(bit v1, bit [7:0] d1, bit v2, bit [7:0] d2, bit ordy,
                              bit r1, bit r2, bit ov, bit [7:0] od, bit os);
    vec_t v;
    v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.ordy = ordy;
    v.r1 = r1; v.r2 = r2; v.ov = ov; v.od = od; v.os = os;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input bit v1, input bit [7:0] d1, input bit v2, input bit [7:0] d2,
                       input bit ordy);
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.in2_valid = v2;
    bus.in2_data  = d2;
    bus.out_ready = ordy;
  endtask

  task automatic set_lock(input bit l1, input bit l2);
`ifdef NML_ARB_LOCK_EN
    bus.in1_lock = l1;
    bus.in2_lock = l2;
`else
    if (l1 | l2) $display("lock requested in a build without lock ports");
`endif
  endtask

  // Leaves the bench at a falling edge with reset released and state IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 8'h00, 0, 8'h00, 1);
    set_lock(0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
    chk({tag, "_out_data"},  32'(bus.out_data),  32'(0));
    chk({tag, "_out_src"},   32'(bus.out_src),   32'(0));
    chk({tag, "_select"},    32'(bus.select),    32'(0));
    chk({tag, "_in1_ready"}, 32'(bus.in1_ready), 32'(0));
    chk({tag, "_in2_ready"}, 32'(bus.in2_ready), 32'(0));
  endtask

  // Reference model state: grant holder (0 none, 1, 2), requester served
  // last, and a plain array of in-flight words ordered from entry to exit.
  int       m_gnt;
  int       m_last;
  bit       m_sel;
  bit       m_pv [S];
  bit [7:0] m_pd [S];
  bit       m_ps [S];

  task automatic model_reset();
    m_gnt  = 0;
    m_last = 2;  // behaves as if in2 was served last: in1 wins the first tie
    m_sel  = 1'b0;
    for (int i = 0; i < S; i++) begin
      m_pv[i] = 1'b0; m_pd[i] = 8'h00; m_ps[i] = 1'b0;
    end
  endtask

  task automatic random_run(input int cycles);
    bit v1, v2, ordy, l1, l2, adv, r1, r2, t1, t2, ov;
    bit [7:0] d1, d2;
    int ng;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      v1   = ($urandom_range(0, 3) != 0);
      v2   = ($urandom_range(0, 3) != 0);
      d1   = 8'($urandom);
      d2   = 8'($urandom);
      ordy = ($urandom_range(0, 4) != 0);
`ifdef NML_ARB_LOCK_EN
      l1 = ($urandom_range(0, 2) == 0);
      l2 = ($urandom_range(0, 2) == 0);
      set_lock(l1, l2);
`else
      l1 = 1'b0;
      l2 = 1'b0;
`endif
      drive(v1, d1, v2, d2, ordy);
      #1;
      ov  = m_pv[S-1];
      adv = !ov || ordy;
      r1  = (m_gnt == 1) && adv;
      r2  = (m_gnt == 2) && adv;
      chk("rnd_in1_ready", 32'(bus.in1_ready), 32'(r1));
      chk("rnd_in2_ready", 32'(bus.in2_ready), 32'(r2));
      chk("rnd_select",    32'(bus.select),    32'(m_sel));
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(ov));
      if (ov) begin
        chk("rnd_out_data", 32'(bus.out_data), 32'(m_pd[S-1]));
        chk("rnd_out_src",  32'(bus.out_src),  32'(m_ps[S-1]));
      end
      t1 = v1 && r1;
      t2 = v2 && r2;
      if (adv) begin
        for (int i = S - 1; i > 0; i--) begin
          m_pv[i] = m_pv[i-1]; m_pd[i] = m_pd[i-1]; m_ps[i] = m_ps[i-1];
        end
        m_pv[0] = t1 || t2;
        m_pd[0] = t1 ? d1 : (t2 ? d2 : 8'h00);
        m_ps[0] = t2;
      end
      if (t1) m_last = 1;
      if (t2) m_last = 2;
      ng = m_gnt;
      if (m_gnt == 0) begin
        if (v1 && v2) ng = (m_last == 1) ? 2 : 1;
        else if (v1)  ng = 1;
        else if (v2)  ng = 2;
      end else if (m_gnt == 1) begin
        if (t1)       ng = (v2 && !l1) ? 2 : 1;
        else if (!v1) ng = 0;
      end else begin
        if (t2)       ng = (v1 && !l2) ? 1 : 2;
        else if (!v2) ng = 0;
      end
      m_gnt = ng;
      if (ng == 1) m_sel = 1'b0;
      if (ng == 2) m_sel = 1'b1;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    // Directed cycle table, starting from IDLE with an empty pipeline.
    tbl[0]  = mk(1, 8'hA5, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0);
    tbl[1]  = mk(1, 8'hA5, 0, 8'h00, 1,  1, 0, 0, 8'h00, 0);
    tbl[2]  = mk(0, 8'h00, 0, 8'h00, 1,  1, 0, 0, 8'h00, 0);
    tbl[3]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0);
    tbl[4]  = mk(1, 8'h11, 1, 8'h22, 1,  0, 0, 1, 8'hA5, 0);
    tbl[5]  = mk(1, 8'h11, 1, 8'h22, 1,  0, 1, 0, 8'h00, 0);
    tbl[6]  = mk(1, 8'h11, 1, 8'h22, 1,  1, 0, 0, 8'h00, 0);
    tbl[7]  = mk(1, 8'h11, 1, 8'h22, 1,  0, 1, 0, 8'h00, 0);
    tbl[8]  = mk(1, 8'h11, 1, 8'h22, 0,  0, 0, 1, 8'h22, 1);
    tbl[9]  = mk(1, 8'h11, 1, 8'h22, 0,  0, 0, 1, 8'h22, 1);
    tbl[10] = mk(1, 8'h11, 1, 8'h22, 1,  1, 0, 1, 8'h22, 1);
    tbl[11] = mk(0, 8'h00, 0, 8'h00, 1,  0, 1, 1, 8'h11, 0);
    tbl[12] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h22, 1);
    tbl[13] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h11, 0);
    tbl[14] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0);

    // Reset with random inputs: outputs cleared during and just after reset.
    reset = 1'b1;
    drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    set_lock(0, 0);
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk_idle_outputs("reset");
    end
    reset = 1'b0;
    #1;
    chk_idle_outputs("post_reset");

    // Directed table.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_in1_ready", i), 32'(bus.in1_ready), 32'(tbl[i].r1));
      chk($sformatf("tbl%0d_in2_ready", i), 32'(bus.in2_ready), 32'(tbl[i].r2));
      chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].od));
        chk($sformatf("tbl%0d_out_src", i),  32'(bus.out_src),  32'(tbl[i].os));
      end
    end

    // Grant revocation: GNT2 loses its valid, falls to IDLE, then in1 is granted.
    do_reset();
    drive(0, 8'h00, 1, 8'h5A, 1);
    #1;
    chk("rev_idle_in2_ready", 32'(bus.in2_ready), 32'(0));
    @(negedge clk);
    drive(1, 8'h3C, 0, 8'h00, 1);
    #1;
    chk("rev_gnt2_in2_ready", 32'(bus.in2_ready), 32'(1));
    chk("rev_gnt2_select",    32'(bus.select),    32'(1));
    @(negedge clk);
    #1;
    chk("rev_back_idle_in1_ready", 32'(bus.in1_ready), 32'(0));
    chk("rev_back_idle_in2_ready", 32'(bus.in2_ready), 32'(0));
    @(negedge clk);
    #1;
    chk("rev_gnt1_in1_ready", 32'(bus.in1_ready), 32'(1));
    chk("rev_gnt1_select",    32'(bus.select),    32'(0));

    // Mid-operation reset with three words in flight: none may ever appear.
    do_reset();
    drive(1, 8'h77, 0, 8'h00, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("flush_pre_out_valid", 32'(bus.out_valid), 32'(1));
    reset = 1'b1;
    drive(0, 8'h00, 0, 8'h00, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("flush_c%0d_out_valid", i), 32'(bus.out_valid), 32'(0));
      @(negedge clk);
    end

`ifdef NML_ARB_LOCK_EN
    // Burst lock: four in1 words in a row, then in2 after the lock drops.
    do_reset();
    drive(1, 8'h01, 1, 8'h02, 1);
    set_lock(1, 0);
    #1;
    chk("lock_idle_in1_ready", 32'(bus.in1_ready), 32'(0));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) set_lock(0, 0);
      #1;
      chk($sformatf("lock_w%0d_in1_ready", k), 32'(bus.in1_ready), 32'(1));
      chk($sformatf("lock_w%0d_in2_ready", k), 32'(bus.in2_ready), 32'(0));
    end
    @(negedge clk);
    #1;
    chk("lock_release_in2_ready", 32'(bus.in2_ready), 32'(1));
    chk("lock_release_in1_ready", 32'(bus.in1_ready), 32'(0));
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    random_run(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
